clk_div_bank: RTL and testbench

- Parametrised bank of independent programmable clock dividers driven from the 100 MHz board clock.
- Each channel produces a divided square/PWM wave with runtime-programmable period and high time, plus a one-cycle tick at each period start.
- Supersedes the fixed single-output divider.
- Feeds LEDs, PMOD pins and slow-rate enables elsewhere in the lab designs.

---
 rtl/clk_div_bank.sv | 110 +++++++++++
 tb/tb_clk_div_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers with shadowed, wrap-synchronous config updates.
// Optional CLK_DIV_SYNC_EN adds a bank-wide sync input that restarts all enabled channels together.
module clk_div_bank #(
    parameter int CHANNELS   = 2,
    parameter int CNT_W      = 30,
    parameter int DEF_PERIOD = 1_000_000,
    parameter int DEF_HIGH   = 500_000,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
`ifdef CLK_DIV_SYNC_EN
    input  logic                sync,
`endif
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_high,
    output logic                cfg_ready,
    input  logic [CHANNELS-1:0] en,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] pending;
    logic [CNT_W-1:0]    wr_period;
    logic [CNT_W-1:0]    wr_high;

    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
        end
    end

    // high is judged against the period as written, so period=1/high=1 stays constant high
    // after the clamp; all-ones high keeps ctr < high true for any legal ctr.
    always_comb begin
        wr_period = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
        if (cfg_high == '0)
            wr_high = '0;
        else if (cfg_high >= cfg_period)
            wr_high = '1;
        else
            wr_high = cfg_high;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] ctr;
        logic [CNT_W-1:0] act_period;
        logic [CNT_W-1:0] act_high;
        logic [CNT_W-1:0] shd_period;
        logic [CNT_W-1:0] shd_high;
        logic             pend_r;
        logic             clk_r;
        logic             tick_r;
        logic             wr_hit;
        logic             wrap;
        logic             restart;
        logic             load;

        assign wr_hit = cfg_we && cfg_ready && (cfg_ch == CH_W'(g));
        assign wrap   = (ctr >= act_period - CNT_W'(1));
`ifdef CLK_DIV_SYNC_EN
        assign restart = wrap || sync;
        assign load    = pend_r && (!en[g] || wrap || sync);
`else
        assign restart = wrap;
        assign load    = pend_r && (!en[g] || wrap);
`endif

        always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
                ctr        <= '0;
                act_period <= CNT_W'(DEF_PERIOD);
                act_high   <= CNT_W'(DEF_HIGH);
                shd_period <= CNT_W'(DEF_PERIOD);
                shd_high   <= CNT_W'(DEF_HIGH);
                pend_r     <= 1'b0;
                clk_r      <= 1'b0;
                tick_r     <= 1'b0;
            end else begin
                if (!en[g]) begin
                    ctr    <= '0;
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                end else begin
                    clk_r  <= (ctr < act_high);
                    tick_r <= (ctr == '0);
                    ctr    <= restart ? '0 : ctr + CNT_W'(1);
                end
                // A write is only accepted with nothing pending, so it never races a load.
                if (wr_hit) begin
                    shd_period <= wr_period;
                    shd_high   <= wr_high;
                    pend_r     <= 1'b1;
                end else if (load) begin
                    act_period <= shd_period;
                    act_high   <= shd_high;
                    pend_r     <= 1'b0;
                end
            end
        end

        assign pending[g] = pend_r;
        assign clk_out[g] = clk_r;
        assign tick[g]    = tick_r;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: defaults, shadowed updates, edge values, enable and reset behaviour.
// Exercises the sync input too when CLK_DIV_SYNC_EN is defined.
module tb_clk_div_bank;
    localparam int CH = 3;
    localparam int W  = 30;

    logic          CLK100MHZ  = 1'b0;
    logic          CPU_RESETN = 1'b0;
    logic          cfg_we     = 1'b0;
    logic [1:0]    cfg_ch     = '0;
    logic [W-1:0]  cfg_period = '0;
    logic [W-1:0]  cfg_high   = '0;
    logic          cfg_ready;
    logic [CH-1:0] en         = '0;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
`ifdef CLK_DIV_SYNC_EN
    logic          sync       = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    clk_div_bank #(
        .CHANNELS(CH), .CNT_W(W), .DEF_PERIOD(10), .DEF_HIGH(5)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .CPU_RESETN(CPU_RESETN),
`ifdef CLK_DIV_SYNC_EN
        .sync      (sync),
`endif
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .cfg_ready (cfg_ready),
        .en        (en),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
    endtask

    // bit j of each vector is the output seen after the (j+1)-th edge
    task automatic cap(input int n, output logic [31:0] c0, output logic [31:0] t0,
                       output logic [31:0] c1, output logic [31:0] t1);
        c0 = '0; t0 = '0; c1 = '0; t1 = '0;
        for (int j = 0; j < n; j++) begin
            step();
            c0[j] = clk_out[0];
            t0[j] = tick[0];
            c1[j] = clk_out[1];
            t1[j] = tick[1];
        end
    endtask

    task automatic write(input logic [1:0] ch, input int p, input int h);
        cfg_ch     = ch;
        cfg_period = W'(p);
        cfg_high   = W'(h);
        cfg_we     = 1'b1;
        step();
        cfg_we     = 1'b0;
    endtask

    // load a channel through the disabled path so the new values start cleanly
    task automatic load_off(input int ch, input int p, input int h);
        en[ch] = 1'b0;
        step();
        write(2'(ch), p, h);
        step();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c0, t0, c1, t1;
        int k;

        en = 3'b011;
        repeat (2) @(negedge CLK100MHZ);
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);

        CPU_RESETN = 1'b1;
        cap(20, c0, t0, c1, t1);
        check("def_clk0", c0, 32'h07C1F);
        check("def_tick0", t0, 32'h00401);
        check("def_clk1", c1, 32'h07C1F);
        check("def_tick1", t1, 32'h00401);
        check("ch2_idle", 32'(clk_out[2]), 32'h0);

        // out-of-range channel is never ready
        cfg_ch = 2'd3; cfg_period = W'(4); cfg_high = W'(1); cfg_we = 1'b1;
        #1;
        check("ready_oob", 32'(cfg_ready), 32'h0);
        step();
        cfg_we = 1'b0;
        step();
        step();

        // both channels now at ctr=3
        cfg_ch = 2'd1;
        #1;
        check("ready_ch1", 32'(cfg_ready), 32'h1);
        write(2'd1, 4, 1);
        check("ready_pend", 32'(cfg_ready), 32'h0);
        write(2'd1, 6, 3);
        repeat (4) step();
        check("ready_hold", 32'(cfg_ready), 32'h0);
        step();
        check("ready_back", 32'(cfg_ready), 32'h1);
        check("old_cfg_last", 32'(clk_out[1]), 32'h0);
        cap(8, c0, t0, c1, t1);
        check("new_clk1", c1, 32'h11);
        check("new_tick1", t1, 32'h11);
        check("keep_clk0", c0, 32'h1F);
        check("keep_tick0", t0, 32'h01);

        en[1] = 1'b0;
        step();
        check("ch1_off", 32'({clk_out[1], tick[1]}), 32'h0);
        write(2'd1, 1, 1);
        step();
        en[1] = 1'b1;
        cap(6, c0, t0, c1, t1);
        check("p1h1_clk", c1, 32'h3F);
        check("p1h1_tick", t1, 32'h15);

        load_off(1, 6, 0);
        en[1] = 1'b1;
        cap(12, c0, t0, c1, t1);
        check("h0_clk", c1, 32'h000);
        check("h0_tick", t1, 32'h041);

        load_off(1, 6, 8);
        en[1] = 1'b1;
        cap(12, c0, t0, c1, t1);
        check("hbig_clk", c1, 32'hFFF);
        check("hbig_tick", t1, 32'h041);

        // disable ch0 mid-high with a write landing on the same edge
        k = 0;
        while (!(clk_out[0] && !tick[0]) && k < 20) begin
            step();
            k++;
        end
        check("ch0_mid_wait", 32'(k < 20), 32'h1);
        en[0] = 1'b0;
        write(2'd0, 4, 3);
        check("off_out0", 32'({clk_out[0], tick[0]}), 32'h0);
        check("off_pend0", 32'(cfg_ready), 32'h0);
        step();
        check("off_apply0", 32'(cfg_ready), 32'h1);
        check("off_still0", 32'(clk_out[0]), 32'h0);
        step();
        en[0] = 1'b1;
        cap(8, c0, t0, c1, t1);
        check("reen_clk0", c0, 32'h77);
        check("reen_tick0", t0, 32'h11);

        // async reset mid-period with a write pending on ch1
        write(2'd1, 3, 1);
        check("pre_rst_pend", 32'(cfg_ready), 32'h0);
        @(posedge CLK100MHZ);
        #2;
        check("pre_rst_clk1", 32'(clk_out[1]), 32'h1);
        #1;
        CPU_RESETN = 1'b0;
        #1;
        check("arst_clk", 32'(clk_out), 32'h0);
        check("arst_tick", 32'(tick), 32'h0);
        check("arst_ready", 32'(cfg_ready), 32'h1);
        @(negedge CLK100MHZ);
        en = 3'b011;
        CPU_RESETN = 1'b1;
        cap(20, c0, t0, c1, t1);
        check("rst2_clk0", c0, 32'h07C1F);
        check("rst2_tick0", t0, 32'h00401);
        check("rst2_clk1", c1, 32'h07C1F);
        check("rst2_tick1", t1, 32'h00401);

`ifdef CLK_DIV_SYNC_EN
        load_off(0, 7, 3);
        load_off(1, 10, 5);
        en[0] = 1'b1;
        repeat (3) step();
        en[1] = 1'b1;
        repeat (2) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        cap(14, c0, t0, c1, t1);
        check("sync_tick0", t0, 32'h0081);
        check("sync_tick1", t1, 32'h0401);
        check("sync_clk0", c0, 32'h0387);
        check("sync_clk1", c1, 32'h3C1F);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
